// File: rtl/spc7110_drom_responder_if.sv
// Bus bundle between the SPC7110 data-ROM requesters, the responder and the PSRAM.
// master: requester/PSRAM side (drives requests, invalidate and the PSRAM read word).
// slave:  the responder (drives read bytes, acks, PSRAM cycle control and busy).
interface spc7110_drom_responder_if;
    logic        dir_req;
    logic [22:0] dir_addr;
    logic [7:0]  dir_data;
    logic        dir_ack;

    logic        dcu_req;
    logic [22:0] dcu_addr;
    logic [7:0]  dcu_data;
    logic        dcu_ack;

    logic        inv;

    logic        ram_req;
    logic [21:0] ram_addr;
    logic [15:0] ram_data;

    logic        busy;

    modport master (
        output dir_req, dir_addr, dcu_req, dcu_addr, inv, ram_data,
        input  dir_data, dir_ack, dcu_data, dcu_ack, ram_req, ram_addr, busy
    );

    modport slave (
        input  dir_req, dir_addr, dcu_req, dcu_addr, inv, ram_data,
        output dir_data, dir_ack, dcu_data, dcu_ack, ram_req, ram_addr, busy
    );
endinterface

// File: rtl/spc7110_drom_responder.sv
// SPC7110 data-ROM byte read responder.
// Two one-entry pending slots (direct port has priority over the DCU), fixed-length
// 16-bit PSRAM word reads, and a one-word buffer that serves sequential byte reads.
module spc7110_drom_responder #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter logic [22:0] DROM_MASK   = 23'h7FFFFF
) (
    input  logic                    CLK,
    input  logic                    RESET,
    spc7110_drom_responder_if.slave io_bus
);
    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_t;

    // Counter starts at WAIT_CYCLES-1 so ram_req stays high exactly WAIT_CYCLES cycles.
    localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

    state_t      r_state,    w_state_d;

    // Pending request slots.
    logic        r_dir_vld,  w_dir_vld_d;
    logic [22:0] r_dir_addr, w_dir_addr_d;
    logic        r_dcu_vld,  w_dcu_vld_d;
    logic [22:0] r_dcu_addr, w_dcu_addr_d;

    // Active request (address plus requester tag: 1 = DCU).
    logic [22:0] r_act_addr, w_act_addr_d;
    logic        r_act_dcu,  w_act_dcu_d;

    // PSRAM cycle control.
    logic [3:0]  r_cnt,      w_cnt_d;
    logic        r_ram_req,  w_ram_req_d;
    logic [21:0] r_ram_addr, w_ram_addr_d;
    logic        r_inv_seen, w_inv_seen_d;

    // One-entry word buffer.
    logic        r_buf_vld,  w_buf_vld_d;
    logic [21:0] r_buf_tag,  w_buf_tag_d;
    logic [15:0] r_buf_word, w_buf_word_d;

    // Requester outputs.
    logic [7:0]  r_dir_data, w_dir_data_d;
    logic        r_dir_ack,  w_dir_ack_d;
    logic [7:0]  r_dcu_data, w_dcu_data_d;
    logic        r_dcu_ack,  w_dcu_ack_d;

    // Slot selection and hit detection for the IDLE decision.
    logic        w_sel_vld;
    logic        w_sel_dcu;
    logic [22:0] w_sel_addr;
    logic        w_hit;
    logic [7:0]  w_buf_byte;
    logic [7:0]  w_ram_byte;

    // Byte delivery for the current edge.
    logic        w_dlv;
    logic        w_dlv_dcu;
    logic [7:0]  w_dlv_byte;

    assign w_sel_vld  = r_dir_vld | r_dcu_vld;
    assign w_sel_dcu  = ~r_dir_vld;
    assign w_sel_addr = r_dir_vld ? r_dir_addr : r_dcu_addr;
    // An invalidate in the decision cycle forces a miss.
    assign w_hit      = r_buf_vld && (r_buf_tag == w_sel_addr[22:1]) && !io_bus.inv;
    // Even byte is the high half of the word.
    assign w_buf_byte = w_sel_addr[0] ? r_buf_word[7:0] : r_buf_word[15:8];
    assign w_ram_byte = r_act_addr[0] ? io_bus.ram_data[7:0] : io_bus.ram_data[15:8];

    // Next-state and output logic: slot bookkeeping, IDLE/ACCESS sequencing, buffer update.
    always_comb begin
        w_state_d    = r_state;
        w_dir_vld_d  = r_dir_vld;
        w_dir_addr_d = r_dir_addr;
        w_dcu_vld_d  = r_dcu_vld;
        w_dcu_addr_d = r_dcu_addr;
        w_act_addr_d = r_act_addr;
        w_act_dcu_d  = r_act_dcu;
        w_cnt_d      = r_cnt;
        w_ram_req_d  = r_ram_req;
        w_ram_addr_d = r_ram_addr;
        w_inv_seen_d = r_inv_seen;
        w_buf_vld_d  = r_buf_vld;
        w_buf_tag_d  = r_buf_tag;
        w_buf_word_d = r_buf_word;
        w_dir_data_d = r_dir_data;
        w_dir_ack_d  = 1'b0;
        w_dcu_data_d = r_dcu_data;
        w_dcu_ack_d  = 1'b0;
        w_dlv        = 1'b0;
        w_dlv_dcu    = 1'b0;
        w_dlv_byte   = 8'h00;

        if (io_bus.inv) begin
            w_buf_vld_d = 1'b0;
        end

        unique case (r_state)
            StIdle: begin
                if (w_sel_vld) begin
                    if (r_dir_vld) begin
                        w_dir_vld_d = 1'b0;
                    end else begin
                        w_dcu_vld_d = 1'b0;
                    end
                    w_act_addr_d = w_sel_addr;
                    w_act_dcu_d  = w_sel_dcu;
                    if (w_hit) begin
                        w_dlv      = 1'b1;
                        w_dlv_dcu  = w_sel_dcu;
                        w_dlv_byte = w_buf_byte;
                    end else begin
                        w_state_d    = StAccess;
                        w_ram_req_d  = 1'b1;
                        w_ram_addr_d = w_sel_addr[22:1];
                        w_cnt_d      = CntLoad;
                        w_inv_seen_d = 1'b0;
                    end
                end
            end
            StAccess: begin
                if (io_bus.inv) begin
                    w_inv_seen_d = 1'b1;
                end
                if (r_cnt == 4'd0) begin
                    w_dlv        = 1'b1;
                    w_dlv_dcu    = r_act_dcu;
                    w_dlv_byte   = w_ram_byte;
                    w_buf_tag_d  = r_act_addr[22:1];
                    w_buf_word_d = io_bus.ram_data;
                    // A word read across an invalidate is delivered but not cached.
                    w_buf_vld_d  = !(r_inv_seen || io_bus.inv);
                    w_ram_req_d  = 1'b0;
                    w_state_d    = StIdle;
                end else begin
                    w_cnt_d = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        if (w_dlv) begin
            if (w_dlv_dcu) begin
                w_dcu_data_d = w_dlv_byte;
                w_dcu_ack_d  = 1'b1;
            end else begin
                w_dir_data_d = w_dlv_byte;
                w_dir_ack_d  = 1'b1;
            end
        end

        // New requests override a same-edge slot clear so they queue rather than vanish.
        if (io_bus.dir_req) begin
            w_dir_vld_d  = 1'b1;
            w_dir_addr_d = io_bus.dir_addr & DROM_MASK;
        end
        if (io_bus.dcu_req) begin
            w_dcu_vld_d  = 1'b1;
            w_dcu_addr_d = io_bus.dcu_addr & DROM_MASK;
        end
    end

    // State register with synchronous reset; a reset drops any in-flight access.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= StIdle;
            r_dir_vld  <= 1'b0;
            r_dir_addr <= 23'd0;
            r_dcu_vld  <= 1'b0;
            r_dcu_addr <= 23'd0;
            r_act_addr <= 23'd0;
            r_act_dcu  <= 1'b0;
            r_cnt      <= 4'd0;
            r_ram_req  <= 1'b0;
            r_ram_addr <= 22'd0;
            r_inv_seen <= 1'b0;
            r_buf_vld  <= 1'b0;
            r_buf_tag  <= 22'd0;
            r_buf_word <= 16'd0;
            r_dir_data <= 8'd0;
            r_dir_ack  <= 1'b0;
            r_dcu_data <= 8'd0;
            r_dcu_ack  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_dir_vld  <= w_dir_vld_d;
            r_dir_addr <= w_dir_addr_d;
            r_dcu_vld  <= w_dcu_vld_d;
            r_dcu_addr <= w_dcu_addr_d;
            r_act_addr <= w_act_addr_d;
            r_act_dcu  <= w_act_dcu_d;
            r_cnt      <= w_cnt_d;
            r_ram_req  <= w_ram_req_d;
            r_ram_addr <= w_ram_addr_d;
            r_inv_seen <= w_inv_seen_d;
            r_buf_vld  <= w_buf_vld_d;
            r_buf_tag  <= w_buf_tag_d;
            r_buf_word <= w_buf_word_d;
            r_dir_data <= w_dir_data_d;
            r_dir_ack  <= w_dir_ack_d;
            r_dcu_data <= w_dcu_data_d;
            r_dcu_ack  <= w_dcu_ack_d;
        end
    end

    assign io_bus.dir_data = r_dir_data;
    assign io_bus.dir_ack  = r_dir_ack;
    assign io_bus.dcu_data = r_dcu_data;
    assign io_bus.dcu_ack  = r_dcu_ack;
    assign io_bus.ram_req  = r_ram_req;
    assign io_bus.ram_addr = r_ram_addr;
    assign io_bus.busy     = (r_state != StIdle) || r_dir_vld || r_dcu_vld;
endmodule

// File: tb/tb_spc7110_drom_responder.sv
// Self-checking bench for spc7110_drom_responder: directed scenarios plus randomized
// single reads, checked against a transaction-level model of the ROM and word buffer.
module tb_spc7110_drom_responder;
    localparam int unsigned W     = 4;
    localparam logic [22:0] MASK1 = 23'h7FFFFF;
    localparam logic [22:0] MASK2 = 23'h0FFFFF;

    logic CLK = 1'b0;
    logic RESET;
    int   n_chk = 0;
    int   n_err = 0;

    // ROM content model: word value is a hash of the word address and a content seed;
    // changing the seed models the MCU rewriting the data ROM.
    logic [15:0] seed = 16'h1234;
    // Word buffer model: holds the last word fetched by a miss, unless invalidated.
    bit          m_vld = 1'b0;
    logic [21:0] m_tag = 22'd0;

    always #5 CLK = ~CLK;

    spc7110_drom_responder_if bus1 ();
    spc7110_drom_responder_if bus2 ();

    spc7110_drom_responder #(
        .WAIT_CYCLES(W),
        .DROM_MASK  (MASK1)
    ) u_dut1 (
        .CLK   (CLK),
        .RESET (RESET),
        .io_bus(bus1)
    );

    spc7110_drom_responder #(
        .WAIT_CYCLES(W),
        .DROM_MASK  (MASK2)
    ) u_dut2 (
        .CLK   (CLK),
        .RESET (RESET),
        .io_bus(bus2)
    );

    function automatic logic [15:0] word_of(input logic [21:0] a, input logic [15:0] s);
        logic [31:0] h;
        if (a == 22'h000008) return 16'hA55A;
        h = {10'd0, a} * 32'h9E3779B1;
        return h[24:9] ^ s;
    endfunction

    function automatic logic [7:0] byte_of(input logic [22:0] ma, input logic [15:0] s);
        logic [15:0] w;
        w = word_of(ma[22:1], s);
        return ma[0] ? w[7:0] : w[15:8];
    endfunction

    // PSRAM model: presents the addressed word while a read cycle is active.
    always_comb bus1.ram_data = bus1.ram_req ? word_of(bus1.ram_addr, seed) : 16'h0000;
    always_comb bus2.ram_data = bus2.ram_req ? word_of(bus2.ram_addr, seed) : 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One read on bus1. mode: 0 plain, 1 ROM rewrite + inv before the request,
    // 2 inv coincident with the hit check, 3 inv during the PSRAM access.
    task automatic do_read(input bit port, input logic [22:0] addr, input int mode,
                           input string name);
        logic [22:0] ma;
        logic [21:0] ra;
        logic [7:0]  got;
        bit          hit, seen, other, ra_bad;
        int          e, rq;
        ma = addr & MASK1;
        if (mode == 1) begin
            bus1.inv = 1'b1;
            seed     = 16'($urandom);
            @(posedge CLK); #1;
            bus1.inv = 1'b0;
            m_vld    = 1'b0;
        end
        hit = m_vld && (m_tag == ma[22:1]) && (mode != 2);
        if (port) begin
            bus1.dcu_req  = 1'b1;
            bus1.dcu_addr = addr;
        end else begin
            bus1.dir_req  = 1'b1;
            bus1.dir_addr = addr;
        end
        e = 0; rq = 0; ra = 'x; got = 'x; seen = 0; other = 0; ra_bad = 0;
        while (!seen && e < 60) begin
            @(posedge CLK); #1;
            e++;
            bus1.dir_req = 1'b0;
            bus1.dcu_req = 1'b0;
            if (e == 1) chk({name, "_busy"}, bus1.busy, 1);
            if (bus1.ram_req) begin
                rq++;
                if (rq == 1) ra = bus1.ram_addr;
                else if (bus1.ram_addr !== ra) ra_bad = 1;
            end
            if (port ? bus1.dir_ack : bus1.dcu_ack) other = 1;
            if (port ? bus1.dcu_ack : bus1.dir_ack) begin
                seen = 1;
                got  = port ? bus1.dcu_data : bus1.dir_data;
            end
            bus1.inv = ((mode == 2) && (e == 1)) || ((mode == 3) && (e == 2));
        end
        bus1.inv = 1'b0;
        chk({name, "_acked"}, seen, 1);
        chk({name, "_latency"}, e, hit ? 2 : W + 2);
        chk({name, "_ramcycles"}, rq, hit ? 0 : W);
        if (!hit) chk({name, "_ramaddr"}, ra, ma[22:1]);
        chk({name, "_addrstable"}, ra_bad, 0);
        chk({name, "_otherack"}, other, 0);
        chk({name, "_data"}, got, byte_of(ma, seed));
        @(posedge CLK); #1;
        chk({name, "_ackpulse"}, port ? bus1.dcu_ack : bus1.dir_ack, 0);
        chk({name, "_idle"}, bus1.busy, 0);
        if (!hit) begin
            m_vld = (mode != 3);
            m_tag = ma[22:1];
        end
    endtask

    initial begin
        int          e, e_da, e_ca, e_cr, both, n_dcu, e_dir, stray;
        int          e_dcu [2];
        logic [7:0]  d_dir;
        logic [7:0]  d_dcu [2];
        logic [21:0] rqa;
        logic [15:0] w2;
        logic [22:0] base;

        RESET = 1'b1;
        bus1.dir_req = 0; bus1.dir_addr = 0; bus1.dcu_req = 0; bus1.dcu_addr = 0; bus1.inv = 0;
        bus2.dir_req = 0; bus2.dir_addr = 0; bus2.dcu_req = 0; bus2.dcu_addr = 0; bus2.inv = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_ram_req", bus1.ram_req, 0);
        chk("reset_ram_addr", bus1.ram_addr, 0);
        chk("reset_acks", {bus1.dir_ack, bus1.dcu_ack}, 0);
        chk("reset_data", {bus1.dir_data, bus1.dcu_data}, 0);
        chk("reset_busy", bus1.busy, 0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        // Direct miss, buffer hit, invalidate-forced misses.
        do_read(0, 23'h000010, 0, "dir_miss");
        do_read(0, 23'h000011, 0, "dir_hit");
        do_read(0, 23'h000011, 1, "inv_before");
        do_read(1, 23'h000011, 2, "inv_at_hit");
        do_read(1, 23'h000010, 0, "dcu_hit");
        do_read(0, 23'h000030, 3, "inv_in_access");
        do_read(0, 23'h000031, 0, "after_inv_access");

        // Same-cycle requests on both ports: direct first, DCU launched after its ack.
        bus1.inv = 1'b1; seed = 16'($urandom);
        @(posedge CLK); #1;
        bus1.inv = 1'b0; m_vld = 0;
        bus1.dir_req = 1; bus1.dir_addr = 23'h000020;
        bus1.dcu_req = 1; bus1.dcu_addr = 23'h000041;
        e = 0; e_da = 0; e_ca = 0; e_cr = 0; both = 0; d_dir = 'x; d_dcu[0] = 'x;
        while (e_ca == 0 && e < 80) begin
            @(posedge CLK); #1;
            e++;
            bus1.dir_req = 0; bus1.dcu_req = 0;
            if (bus1.dir_ack && e_da == 0) begin e_da = e; d_dir = bus1.dir_data; end
            if (bus1.dcu_ack) begin e_ca = e; d_dcu[0] = bus1.dcu_data; end
            if (bus1.ram_req && bus1.ram_addr == 22'h000020 && e_cr == 0) e_cr = e;
            if (bus1.dir_ack && bus1.dcu_ack) both++;
        end
        chk("same_dir_ack_time", e_da, W + 2);
        chk("same_dcu_ramreq_start", e_cr, W + 3);
        chk("same_dcu_ack_time", e_ca, 2 * W + 3);
        chk("same_dir_data", d_dir, byte_of(23'h000020, seed));
        chk("same_dcu_data", d_dcu[0], byte_of(23'h000041, seed));
        chk("same_ack_overlap", both, 0);
        m_vld = 1; m_tag = 22'h000020;
        @(posedge CLK); #1;

        // Non-preemption: direct and a DCU re-request arrive during a DCU access.
        bus1.dcu_req = 1; bus1.dcu_addr = 23'h000100;
        e = 0; n_dcu = 0; e_dir = 0; both = 0;
        e_dcu[0] = 0; e_dcu[1] = 0; d_dcu[0] = 'x; d_dcu[1] = 'x; d_dir = 'x;
        while (n_dcu < 2 && e < 100) begin
            @(posedge CLK); #1;
            e++;
            bus1.dcu_req = 0; bus1.dir_req = 0;
            if (bus1.dcu_ack) begin
                e_dcu[n_dcu] = e; d_dcu[n_dcu] = bus1.dcu_data; n_dcu++;
            end
            if (bus1.dir_ack && e_dir == 0) begin e_dir = e; d_dir = bus1.dir_data; end
            if (bus1.dir_ack && bus1.dcu_ack) both++;
            if (e == 2) begin
                bus1.dir_req = 1; bus1.dir_addr = 23'h000200;
                bus1.dcu_req = 1; bus1.dcu_addr = 23'h000301;
            end
        end
        chk("np_dcu1_time", e_dcu[0], W + 2);
        chk("np_dir_time", e_dir, 2 * W + 3);
        chk("np_dcu2_time", e_dcu[1], 3 * W + 4);
        chk("np_dcu1_data", d_dcu[0], byte_of(23'h000100, seed));
        chk("np_dir_data", d_dir, byte_of(23'h000200, seed));
        chk("np_dcu2_data", d_dcu[1], byte_of(23'h000301, seed));
        chk("np_ack_overlap", both, 0);
        m_vld = 1; m_tag = 22'h000180;
        @(posedge CLK); #1;

        // Address masking on the second instance.
        bus2.dcu_req = 1; bus2.dcu_addr = 23'h7FFFFF;
        @(posedge CLK); #1;
        bus2.dcu_req = 0;
        e = 1; rqa = 'x;
        while (!bus2.dcu_ack && e < 60) begin
            if (bus2.ram_req) rqa = bus2.ram_addr;
            @(posedge CLK); #1;
            e++;
        end
        w2 = word_of(22'h07FFFF, seed);
        chk("mask_latency", e, W + 2);
        chk("mask_ram_addr", rqa, 22'h07FFFF);
        chk("mask_data", bus2.dcu_data, w2[7:0]);
        @(posedge CLK); #1;

        // Randomized reads over a few clustered address windows.
        base = 23'd0;
        for (int i = 0; i < 40; i++) begin
            logic [22:0] a, ma;
            bit          pm;
            int          r, md;
            if (i % 8 == 0) base = 23'($urandom) & 23'h7FFFF8;
            a  = base + 23'($urandom_range(0, 5));
            ma = a & MASK1;
            pm = !(m_vld && (m_tag == ma[22:1]));
            r  = int'($urandom_range(0, 9));
            md = (r == 0) ? 1 : (r == 1) ? 2 : ((r == 2) && pm) ? 3 : 0;
            do_read(1'($urandom_range(0, 1)), a, md, "rand");
        end

        // Reset in the middle of an access.
        do_read(0, 23'h000500, 0, "pre_reset");
        bus1.dir_req = 1; bus1.dir_addr = 23'h000400;
        @(posedge CLK); #1;
        bus1.dir_req = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("midacc_ram_req", bus1.ram_req, 1);
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ram_req", bus1.ram_req, 0);
        chk("rst_ram_addr", bus1.ram_addr, 0);
        chk("rst_acks", {bus1.dir_ack, bus1.dcu_ack}, 0);
        chk("rst_data", {bus1.dir_data, bus1.dcu_data}, 0);
        chk("rst_busy", bus1.busy, 0);
        RESET = 1'b0;
        stray = 0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (bus1.dir_ack || bus1.dcu_ack || bus1.ram_req) stray++;
        end
        chk("rst_dropped", stray, 0);
        m_vld = 0;
        do_read(0, 23'h000501, 0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/spc7110_drom_responder.md
# spc7110_drom_responder

PSRAM-side responder for SPC7110 data-ROM byte reads. Accepts one-byte read requests from the direct-access MMIO port (highest priority) and the decompression unit (DCU), runs 16-bit PSRAM word reads with a fixed access time, and returns the selected byte with a one-cycle acknowledge. A one-entry word buffer answers sequential `$4800`-style reads without a PSRAM cycle.

## Interface
- `WAIT_CYCLES`, 4: PSRAM access length in CLK cycles, 1..15; `ram_req` stays high this many cycles.
- `DROM_MASK`, 23'h7FFFFF: AND-mask applied to every request byte address before use.
- `CLK` in 1: system clock.
- `RESET` in 1: reset RESET, synchronous, active-high; clock CLK.
- `dir_req` in 1: direct-port read request, one-cycle pulse.
- `dir_addr` in 23: direct-port byte address, sampled with `dir_req`.
- `dir_data` out 8: direct-port read byte, held until next `dir_ack`.
- `dir_ack` out 1: one-cycle pulse, `dir_data` valid.
- `dcu_req` / `dcu_addr` / `dcu_data` / `dcu_ack`: same as `dir_*`, for DCU.
- `inv` in 1: invalidate word buffer (data ROM rewritten by MCU).
- `ram_req` out 1: PSRAM read cycle active.
- `ram_addr` out 22: PSRAM word address (byte address bits [22:1]).
- `ram_data` in 16: PSRAM read word, sampled on last access cycle.
- `busy` out 1: state not IDLE or any pending slot occupied.

## Operation
- Pending slots: one per requester (valid bit + masked 23-bit address). `*_req` sets the slot and loads the address; a `*_req` while the slot is already valid overwrites the address (latest wins). The slot clears at the edge its request is launched; a request arriving during its own access therefore queues.
- States: IDLE, ACCESS.
- IDLE: selects the direct slot if valid, else the DCU slot, else stays. Selected slot cleared; its address moves to the active register along with a requester tag.
- Hit (buffer valid, tag == addr[22:1], `inv` low this cycle): byte driven to the requester's data output, ack pulsed at the same edge, remain IDLE.
- Miss: go to ACCESS; `ram_req`=1, `ram_addr`=addr[22:1], counter=WAIT_CYCLES-1.
- ACCESS: counter decrements each edge. At the edge where counter==0: capture `ram_data`, deliver byte, pulse ack, load buffer tag/word, set valid unless `inv` was seen during the access; `ram_req`=0; return to IDLE.
- Byte select: addr[0]=0 gives `ram_data[15:8]`, addr[0]=1 gives `ram_data[7:0]`.
- Priority is non-preemptive: an active DCU access always completes; direct is taken at the next IDLE decision.
- `inv`: clears buffer valid at once; if it arrives during ACCESS, the captured word is still delivered but not cached; `inv` coincident with a hit check forces a miss.
- Requests on both ports in the same cycle: both slots set, direct served first.
- Reset (any time, including mid-access): state IDLE, slots and buffer invalid, `ram_req`=0, `ram_addr`=0, `dir_data`=`dcu_data`=0, acks 0, `busy`=0; an in-flight access is dropped with no ack.

## Timing
- `*_req` is sampled at edge N; the slot is valid after N; the IDLE decision happens at edge N+1 (when the FSM is idle).
- Hit: ack is high in the cycle after edge N+1 (2-cycle latency).
- Miss: `ram_req` is high from edge N+1 to edge N+1+WAIT_CYCLES; ack is high in the cycle after edge N+1+WAIT_CYCLES (WAIT_CYCLES+2 latency; 6 for the default).
- Back-to-back: IDLE resumes after the ack edge, so a queued access launches one edge later. Acks never overlap; at most one ack pulses per cycle.
- `ram_addr` is stable for the whole `ram_req` window.

## Test plan
- Reset: hold RESET 3 cycles mid-access -> `ram_req`=0, acks 0, data 0, `busy`=0; the dropped request is never acked.
- Direct miss: WAIT_CYCLES=4, `dir_addr`=23'h000010, `ram_data`=16'hA55A -> `ram_addr`=22'h000008, `ram_req` high 4 cycles, `dir_data`=8'hA5, `dir_ack` one cycle at N+5/N+6.
- Buffer hit: then `dir_addr`=23'h000011 -> no `ram_req`, `dir_ack` 2 cycles after request, `dir_data`=8'h5A; assert `inv` first -> miss with a full 4-cycle `ram_req`.
- Same-cycle requests: `dir_addr`=23'h000020 and `dcu_addr`=23'h000041 at edge N -> direct acked first (after N+5), DCU `ram_req` starts at N+6, `dcu_ack` after N+10.
- Non-preemption: `dir_req` 2 cycles into a DCU access -> DCU completes and acks, then the direct access runs; queued DCU re-request during its own access -> acked after.
- Masking: DROM_MASK=23'h0FFFFF, `dcu_addr`=23'h7FFFFF -> `ram_addr`=22'h07FFFF, low byte returned.
